// File: rtl/ssc_pkg.sv
// Shared definitions for the serial stream generator: FSM state encoding
// and the odd-parity helper used when the parity bit is enabled.
package ssc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } ssc_state_e;

  // Odd parity over a frame zero-extended to 64 bits (zero-extension does not
  // change the XOR reduction, so any FRAME_W up to 64 can use it).
  function automatic logic odd_parity(input logic [63:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/ssc_bit_timer.sv
// Bit-period divider for the serial stream generator. Counts 0..CLK_DIV-1
// while enabled, wraps on tick, and reports the last and next-to-last count
// plus whether the next count lies in the upper half of the bit period.
module ssc_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_main,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic pre_tick,
  output logic half_next
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Next count and decoded tick / half-period flags.
  always_comb begin
    tick     = (count_q == DIV_W'(CLK_DIV - 1));
    pre_tick = (count_q == DIV_W'(CLK_DIV - 2));
    if (clr || !en || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
    half_next = (count_d >= DIV_W'(CLK_DIV / 2));
  end

  // Divider register.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ssc_stream_gen.sv
// Serial stream generator: serialises FRAME_W-bit frames MSB first, one bit
// per CLK_DIV cycles, with a mid-bit rising serial clock and an idle gap of
// GAP_BITS bit periods between frames.
// Optional feature: define SSC_STREAM_PARITY_EN to append an odd-parity bit.
module ssc_stream_gen
  import ssc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int FRAME_W  = 8,
  parameter int GAP_BITS = 2
) (
  input  logic               clk_main,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               data_out,
  output logic               bit_strobe,
  output logic               clk_out,
  output logic               busy
);

  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  ssc_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               data_out_q, data_out_d;
  logic               bit_strobe_q, bit_strobe_d;
  logic               clk_out_q, clk_out_d;
`ifdef SSC_STREAM_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic accept;
  logic frame_done;
  logic tick;
  logic pre_tick;
  logic half_next;

  assign accept      = (state_q == ST_IDLE) && frame_valid;
  assign frame_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign data_out    = data_out_q;
  assign bit_strobe  = bit_strobe_q;
  assign clk_out     = clk_out_q;

  ssc_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_main  (clk_main),
    .rst_n     (rst_n),
    .clr       (accept),
    .en        (busy),
    .tick      (tick),
    .pre_tick  (pre_tick),
    .half_next (half_next)
  );

  // Next-state, shift datapath and registered output values.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    data_out_d   = data_out_q;
    bit_strobe_d = 1'b0;
    frame_done   = 1'b0;
`ifdef SSC_STREAM_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        data_out_d = 1'b0;
        if (accept) begin
          shreg_d      = frame_in;
          data_out_d   = frame_in[FRAME_W-1];
          bit_strobe_d = 1'b1;
          bit_cnt_d    = BIT_W'(FRAME_W - 1);
          state_d      = ST_SHIFT;
`ifdef SSC_STREAM_PARITY_EN
          parity_d     = odd_parity(64'(frame_in));
`endif
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (bit_cnt_q != '0) begin
            shreg_d      = shreg_q << 1;
            data_out_d   = shreg_d[FRAME_W-1];
            bit_strobe_d = 1'b1;
            bit_cnt_d    = bit_cnt_q - BIT_W'(1);
          end else begin
`ifdef SSC_STREAM_PARITY_EN
            data_out_d   = parity_q;
            bit_strobe_d = 1'b1;
            state_d      = ST_PAR;
`else
            frame_done   = 1'b1;
`endif
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          frame_done = 1'b1;
        end
      end
      ST_GAP: begin
        // Leave one cycle before the last gap bit ends: the single IDLE
        // cycle completes the gap, so back-to-back frames see exactly
        // GAP_BITS*CLK_DIV zero cycles between them.
        if (pre_tick && (gap_cnt_q == GAP_W'(GAP_BITS - 1))) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_done) begin
      data_out_d = 1'b0;
      if (GAP_BITS == 0) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
    end

    clk_out_d = ((state_d == ST_SHIFT) || (state_d == ST_PAR)) && half_next;
  end

  // State and output registers; reset aborts any partial frame.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      data_out_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      clk_out_q    <= 1'b0;
`ifdef SSC_STREAM_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      data_out_q   <= data_out_d;
      bit_strobe_q <= bit_strobe_d;
      clk_out_q    <= clk_out_d;
`ifdef SSC_STREAM_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_ssc_stream_gen.sv
// Directed bench for ssc_stream_gen (CLK_DIV=4, FRAME_W=8, GAP_BITS=2).
// Honours SSC_STREAM_PARITY_EN to expect the appended parity bit.
module tb_ssc_stream_gen;

  localparam int CLK_DIV  = 4;
  localparam int FRAME_W  = 8;
  localparam int GAP_BITS = 2;
`ifdef SSC_STREAM_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk_main = 1'b0;
  logic       rst_n;
  logic [7:0] frame_in;
  logic       frame_valid;
  logic       frame_ready;
  logic       data_out;
  logic       bit_strobe;
  logic       clk_out;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_main = ~clk_main;

  ssc_stream_gen #(
    .CLK_DIV  (CLK_DIV),
    .FRAME_W  (FRAME_W),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk_main    (clk_main),
    .rst_n       (rst_n),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .data_out    (data_out),
    .bit_strobe  (bit_strobe),
    .clk_out     (clk_out),
    .busy        (busy)
  );

  // Downstream sequence-checker model: samples data_out on bit_strobe and
  // flags the first time the last eight bits equal 8'h0B.
  logic       chk_clr = 1'b0;
  logic [7:0] chk_sr;
  int         chk_cnt;
  logic       chk_det;
  int         chk_det_at;

  always_ff @(posedge clk_main) begin
    if (chk_clr) begin
      chk_sr     <= 8'h00;
      chk_cnt    <= 0;
      chk_det    <= 1'b0;
      chk_det_at <= 0;
    end else if (bit_strobe) begin
      chk_sr  <= {chk_sr[6:0], data_out};
      chk_cnt <= chk_cnt + 1;
      if (({chk_sr[6:0], data_out} == 8'h0B) && !chk_det) begin
        chk_det    <= 1'b1;
        chk_det_at <= chk_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [7:0] frame;
    logic [7:0] exp_seq;   // wire order, first bit in the leftmost position
    logic       exp_par;   // odd parity, hand-computed
    int         mode;      // 0 pulse, 1 hold valid, 2 poke valid mid-frame
    logic [7:0] other;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sends one frame and checks every cycle of the stream and the idle gap.
  task automatic send_frame(input vec_t v);
    int   waited = 0;
    int   bidx;
    logic exp_d;
    logic in_bits;
    logic last;
    while (!frame_ready && waited < 100) begin
      @(negedge clk_main);
      waited++;
    end
    chk("ready_before_send", frame_ready, 1);
    frame_in    = v.frame;
    frame_valid = 1'b1;
    for (int k = 0; k < NB * 4 + 8; k++) begin
      @(negedge clk_main);
      bidx    = k / 4;
      in_bits = (k < NB * 4);
      last    = (k == NB * 4 + 7);
      if (bidx < 8)       exp_d = v.exp_seq[7 - bidx];
      else if (bidx == 8 && NB == 9) exp_d = v.exp_par;
      else                exp_d = 1'b0;
      chk($sformatf("data_out f=%h k=%0d", v.frame, k), data_out, exp_d);
      chk($sformatf("bit_strobe f=%h k=%0d", v.frame, k), bit_strobe, in_bits && (k % 4 == 0));
      chk($sformatf("clk_out f=%h k=%0d", v.frame, k), clk_out, in_bits && (k % 4 >= 2));
      chk($sformatf("busy f=%h k=%0d", v.frame, k), busy, !last);
      chk($sformatf("frame_ready f=%h k=%0d", v.frame, k), frame_ready, last);
      if (k == 0) begin
        if (v.mode == 1) frame_in = v.other;
        else             frame_valid = 1'b0;
      end
      if (v.mode == 2 && k == 10) begin
        frame_valid = 1'b1;
        frame_in    = v.other;
      end
      if (v.mode == 2 && k == 11) begin
        frame_valid = 1'b0;
        frame_in    = v.frame;
      end
    end
    $display("frame %h mode %0d streamed, compared=%0d mismatched=%0d", v.frame, v.mode, n_cmp, n_err);
  endtask

  initial begin
    vecs[0] = '{frame: 8'hB0, exp_seq: 8'b1011_0000, exp_par: 1'b0, mode: 0, other: 8'h00};
    vecs[1] = '{frame: 8'hFF, exp_seq: 8'b1111_1111, exp_par: 1'b1, mode: 1, other: 8'h0B};
    vecs[2] = '{frame: 8'h0B, exp_seq: 8'b0000_1011, exp_par: 1'b0, mode: 0, other: 8'h00};
    vecs[3] = '{frame: 8'hB1, exp_seq: 8'b1011_0001, exp_par: 1'b1, mode: 2, other: 8'h55};
    vecs[4] = '{frame: 8'h00, exp_seq: 8'b0000_0000, exp_par: 1'b1, mode: 0, other: 8'h00};
    vecs[5] = '{frame: 8'hA5, exp_seq: 8'b1010_0101, exp_par: 1'b1, mode: 0, other: 8'h00};

    frame_in    = 8'h00;
    frame_valid = 1'b0;
    rst_n       = 1'b1;
    #2 rst_n    = 1'b0;
    #1;
    chk("reset data_out", data_out, 0);
    chk("reset bit_strobe", bit_strobe, 0);
    chk("reset clk_out", clk_out, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_ready", frame_ready, 1);
    repeat (3) @(negedge clk_main);
    rst_n = 1'b1;
    @(negedge clk_main);
    $display("reset released, compared=%0d mismatched=%0d", n_cmp, n_err);

    // Vector table: pulse, back-to-back hold, ignored mid-frame poke, zeros.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i]);
    end

    // Reset in the middle of the 4th bit of 8'hB0 (bit value 1, clk_out high).
    frame_in    = 8'hB0;
    frame_valid = 1'b1;
    @(negedge clk_main);
    frame_valid = 1'b0;
    repeat (14) @(negedge clk_main);
    chk("pre_reset data_out", data_out, 1);
    chk("pre_reset clk_out", clk_out, 1);
    chk("pre_reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset data_out", data_out, 0);
    chk("midreset clk_out", clk_out, 0);
    chk("midreset busy", busy, 0);
    chk("midreset bit_strobe", bit_strobe, 0);
    chk("midreset frame_ready", frame_ready, 1);
    $display("mid-frame reset applied, compared=%0d mismatched=%0d", n_cmp, n_err);
    repeat (2) @(negedge clk_main);
    rst_n = 1'b1;
    @(negedge clk_main);
    send_frame(vecs[5]);

    // Chain into the checker model with frame 8'h0B.
    chk_clr = 1'b1;
    @(negedge clk_main);
    chk_clr = 1'b0;
    send_frame(vecs[2]);
    chk("checker detect", chk_det, 1);
    chk("checker detect bit index", chk_det_at, 8);
    chk("checker strobe count", chk_cnt, NB);
    $display("checker chain: detect=%0b at bit %0d", chk_det, chk_det_at);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
